regfile_scanner: RTL and testbench
==================================

Name: regfile_scanner

Overview:
- Read-side sequencer for the 32x32 register file. On a start pulse it walks a contiguous range of register indices through one register-file read port.
- For each index it captures the 32-bit value and presents it, with the index, on a valid/ready output stream. The stream feeds the board debug path (7-seg/LED display driver or UART dumper).
- Supports single-shot and continuous scan, an optional dwell gap between beats for human-readable displays, and abort.

Parameters:
FIRST_REG, 0, first register index scanned (0..31)
LAST_REG, 31, last register index scanned (FIRST_REG..31); FIRST_REG > LAST_REG is illegal
DWELL_CYCLES, 0, idle cycles inserted after each accepted beat before the next read
DWELL_W, 24, width of dwell counter; DWELL_CYCLES < 2**DWELL_W

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin scan; sampled only in IDLE
cont  in  1  continuous mode; sampled together with start and held for the scan
abort  in  1  synchronous stop; highest priority after reset
rd_addr  out  5  register file read address (registered)
rd_data  in  32  register file read data (combinational read of rd_addr)
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat when out_valid & out_ready
out_idx  out  5  register index of current beat
out_data  out  32  captured register value
busy  out  1  scan in progress
done  out  1  one-cycle pulse at end of single-shot scan

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; rd_addr=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0, dwell counter=0, cont latch=0. Reset mid-scan discards the beat in flight with no done pulse.
- States: IDLE, READ, PRESENT, GAP, DONE. busy=1 in READ/PRESENT/GAP, 0 in IDLE/DONE.
- IDLE: start=1 -> READ next cycle, rd_addr<=FIRST_REG, cont latched. start outside IDLE is ignored.
- READ (exactly 1 cycle): at the closing edge out_data<=rd_data, out_idx<=rd_addr, out_valid<=1, next PRESENT.
- PRESENT: out_valid, out_idx and out_data are held stable until the handshake. On handshake (out_valid & out_ready at the edge), out_valid<=0, then:
  - rd_addr!=LAST_REG: rd_addr<=rd_addr+1.
  - rd_addr==LAST_REG and cont=1: rd_addr<=FIRST_REG, scan repeats.
  - rd_addr==LAST_REG and cont=0: go to DONE.
  - Next state for the first two cases: GAP if DWELL_CYCLES>0, else READ.
- GAP: counter loads DWELL_CYCLES on entry and decrements each cycle; leave for READ when it reaches 1, giving exactly DWELL_CYCLES GAP cycles.
- DONE: done=1 for exactly one cycle, then IDLE. rd_addr keeps its last value.
- Throughput with out_ready=1 and DWELL=0: one beat per 2 cycles. Latency from the start edge to the first out_valid is 2 cycles.
- abort=1 in any non-IDLE state -> IDLE next cycle, out_valid<=0, no done pulse. abort beats a simultaneous handshake; that beat counts as not delivered. abort in IDLE beats start.
- Coherency: each value is the register content at the READ closing edge. A register-file write on that same edge is not captured; the old value is presented. Writes after capture do not alter out_data.
- Index arithmetic is 5-bit, and the range never wraps past 31 because the LAST_REG compare happens first.
- Range FIRST_REG==LAST_REG is legal: one beat per pass.

Test Plan:
- Single-shot full range: preload reg[i]=i*32'h01010101, out_ready=1, DWELL=0, start at edge 0. Expect out_valid high at cycles 2,4,...,64 carrying (i, i*32'h01010101) for i=0..31. done=1 at cycle 65 only. busy high cycles 1..64.
- Backpressure: out_ready low for 5 cycles while beat idx=3 is presented. Expect out_idx=3 and out_data=32'h03030303 held stable with no skipped or duplicated index; idx=4 follows after ready rises.
- Dwell/range: FIRST_REG=8, LAST_REG=10, DWELL_CYCLES=3, ready=1. Expect beats at cycles 2, 7, 12 with idx 8,9,10, and done at cycle 13.
- Continuous + abort: cont=1, range 30..31. Expect idx sequence 30,31,30,31,... with no done. Assert abort in the same cycle as the handshake of idx 31. Expect out_valid=0 and busy=0 next cycle, no done, then a new start works.
- Concurrent write: reg[5]=32'hAAAA0000, write 32'h5555FFFF to reg 5 on the READ closing edge for idx 5. Expect 32'hAAAA0000 presented; a second scan returns 32'h5555FFFF.
- Async reset mid-PRESENT: drop rst_n between edges. Expect out_valid, busy, done and rd_addr at 0 immediately, before the next clk edge; start after release gives a clean scan from FIRST_REG.

Source files
------------

// File: rtl/regfile_scanner.sv
// regfile_scanner
// Read-side sequencer for the 32x32 register file. A start pulse walks the
// index range FIRST_REG..LAST_REG through one read port. Each value is
// captured and presented with its index on a valid/ready stream. The
// stream can run once (single-shot) or repeat (continuous). An optional
// dwell gap can separate beats, and a scan can be aborted.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   start      begin scan (sampled only in IDLE)
//   cont       continuous mode, latched together with start
//   abort      synchronous stop, wins over everything except reset
//   rd_addr    register file read address (registered)
//   rd_data    register file read data (combinational read of rd_addr)
//   out_valid  beat available
//   out_ready  consumer accepts beat when out_valid & out_ready
//   out_idx    register index of the current beat
//   out_data   captured register value
//   busy       scan in progress (READ/PRESENT/GAP)
//   done       one-cycle pulse at the end of a single-shot scan
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// READ    | rd_addr driven; value captured at the closing edge
// PRESENT | beat held on the output until handshake
// GAP     | dwell down-counter running between beats
// DONE    | single-shot scan finished, done pulse for one cycle
module regfile_scanner #(
  parameter int FIRST_REG    = 0,
  parameter int LAST_REG     = 31,
  parameter int DWELL_CYCLES = 0,
  parameter int DWELL_W      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_PRESENT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [4:0]         FIRST_A  = 5'(FIRST_REG);
  localparam logic [4:0]         LAST_A   = 5'(LAST_REG);
  localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL_CYCLES);
  localparam logic               HAS_GAP  = (DWELL_CYCLES > 0);

  state_t             state_q;
  state_t             state_d;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               cont_q;
  logic               hs;
  logic               at_last;

  assign hs      = out_valid & out_ready;
  // The LAST_REG compare runs before the increment, so rd_addr never wraps.
  assign at_last = (rd_addr == LAST_A);

  assign busy = (state_q == S_READ) || (state_q == S_PRESENT) || (state_q == S_GAP);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_READ;
      end
      S_READ: begin
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (hs) begin
          if (at_last && !cont_q) state_d = S_DONE;
          else if (HAS_GAP)       state_d = S_GAP;
          else                    state_d = S_READ;
        end
      end
      S_GAP: begin
        // Terminal count at 1 gives exactly DWELL_CYCLES cycles in GAP.
        if (dwell_cnt <= DWELL_W'(1)) state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over start in IDLE and over a same-cycle handshake.
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      dwell_cnt <= '0;
      cont_q    <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_addr <= FIRST_A;
            cont_q  <= cont;
          end
        end
        S_READ: begin
          // A write landing on this same edge is not seen: rd_data is
          // still the old content while the capture happens.
          out_data  <= rd_data;
          out_idx   <= rd_addr;
          out_valid <= 1'b1;
        end
        S_PRESENT: begin
          if (hs) begin
            out_valid <= 1'b0;
            dwell_cnt <= DWELL_LD;
            if (!at_last)    rd_addr <= rd_addr + 5'd1;
            else if (cont_q) rd_addr <= FIRST_A;
          end
        end
        S_GAP: begin
          if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scanner.sv
module tb_regfile_scanner;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start     [3];
  logic        cont      [3];
  logic        abort     [3];
  logic        out_ready [3];
  logic        out_valid [3];
  logic        busy      [3];
  logic        done      [3];
  logic [4:0]  rd_addr   [3];
  logic [4:0]  out_idx   [3];
  logic [31:0] rd_data   [3];
  logic [31:0] out_data  [3];
  logic [31:0] rf        [3][32];

  exp_t sb_q   [3][$];
  int   done_q [3][$];
  int   t_start[3];
  int   ncyc  = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t mon_e;
  int   mon_c;
  int   mon_d;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  // Instance 0: full range, no dwell. 1: 8..10 with dwell 3. 2: 30..31.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int FR = (g == 0) ? 0  : ((g == 1) ? 8  : 30);
    localparam int LR = (g == 0) ? 31 : ((g == 1) ? 10 : 31);
    localparam int DW = (g == 1) ? 3 : 0;
    regfile_scanner #(
      .FIRST_REG   (FR),
      .LAST_REG    (LR),
      .DWELL_CYCLES(DW),
      .DWELL_W     (24)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .cont     (cont[g]),
      .abort    (abort[g]),
      .rd_addr  (rd_addr[g]),
      .rd_data  (rd_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_idx  (out_idx[g]),
      .out_data (out_data[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
    assign rd_data[g] = rf[g][rd_addr[g]];
  end

  function automatic logic [31:0] pat(int i);
    return 32'(i) * 32'h01010101;
  endfunction

  function automatic int cyc_of(int g);
    return ncyc - t_start[g] + 1;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic push_beat(int g, int idx, logic [31:0] d, int c);
    exp_t e;
    e.idx  = 5'(idx);
    e.data = d;
    e.cyc  = c;
    sb_q[g].push_back(e);
  endtask

  // Returns in the drive slot of cycle 1 (just after the start edge).
  task automatic start_scan(int g, logic c);
    @(posedge clk); #1;
    start[g]   = 1'b1;
    cont[g]    = c;
    t_start[g] = ncyc + 1;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic goto(int g, int n);
    int guard;
    guard = 0;
    while (cyc_of(g) < n && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) check("goto_timeout", 32'(cyc_of(g)), 32'(n));
  endtask

  // Scoreboard monitor: pops an expected beat on every delivered handshake.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst_n && out_valid[g] && out_ready[g] && !abort[g]) begin
        total++;
        mon_c = cyc_of(g);
        if (sb_q[g].size() == 0) begin
          bad++;
          $display("FAIL beat%0d unexpected: idx=%0d data=%h cycle=%0d", g, out_idx[g], out_data[g], mon_c);
        end else begin
          mon_e = sb_q[g].pop_front();
          if (out_idx[g] !== mon_e.idx || out_data[g] !== mon_e.data || mon_c != mon_e.cyc) begin
            bad++;
            $display("FAIL beat%0d: got idx=%0d data=%h cycle=%0d want idx=%0d data=%h cycle=%0d",
                     g, out_idx[g], out_data[g], mon_c, mon_e.idx, mon_e.data, mon_e.cyc);
          end
        end
      end
      if (rst_n && done[g]) begin
        total++;
        mon_c = cyc_of(g);
        if (done_q[g].size() == 0) begin
          bad++;
          $display("FAIL done%0d unexpected: cycle=%0d", g, mon_c);
        end else begin
          mon_d = done_q[g].pop_front();
          if (mon_c != mon_d) begin
            bad++;
            $display("FAIL done%0d: got cycle=%0d want cycle=%0d", g, mon_c, mon_d);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g]     = 1'b0;
      cont[g]      = 1'b0;
      abort[g]     = 1'b0;
      out_ready[g] = 1'b1;
      t_start[g]   = 0;
      for (int i = 0; i < 32; i++) rf[g][i] <= pat(i);
    end
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid[0]), 0);
    check("rst_addr",  32'(rd_addr[0]),   0);
    check("rst_idx",   32'(out_idx[0]),   0);
    check("rst_data",  out_data[0],       0);
    check("rst_busy",  32'(busy[0]),      0);
    check("rst_done",  32'(done[0]),      0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single-shot full range.
    for (int i = 0; i < 32; i++) push_beat(0, i, pat(i), 2 + 2 * i);
    done_q[0].push_back(65);
    start_scan(0, 1'b0);
    for (int n = 1; n <= 66; n++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", n), 32'(busy[0]), 32'(n <= 64));
      @(posedge clk); #1;
    end

    // Backpressure on idx 3 for 5 cycles.
    for (int i = 0; i < 32; i++)
      push_beat(0, i, pat(i), (i < 3) ? 2 + 2 * i : ((i == 3) ? 13 : 2 * i + 7));
    done_q[0].push_back(70);
    start_scan(0, 1'b0);
    goto(0, 8);
    out_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid[0]), 1);
      check("bp_idx",   32'(out_idx[0]),   3);
      check("bp_data",  out_data[0],       32'h03030303);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    goto(0, 72);
    @(negedge clk);
    check("done_addr_kept", 32'(rd_addr[0]), 31);
    check("bp_sb_empty", 32'(sb_q[0].size()), 0);

    // Dwell and sub-range.
    push_beat(1, 8,  pat(8),  2);
    push_beat(1, 9,  pat(9),  7);
    push_beat(1, 10, pat(10), 12);
    done_q[1].push_back(13);
    start_scan(1, 1'b0);
    goto(1, 5);
    @(negedge clk);
    check("gap_busy",  32'(busy[1]),      1);
    check("gap_valid", 32'(out_valid[1]), 0);
    @(posedge clk); #1;
    goto(1, 15);

    // Continuous 30..31, abort on the handshake of idx 31.
    push_beat(2, 30, pat(30), 2);
    push_beat(2, 31, pat(31), 4);
    push_beat(2, 30, pat(30), 6);
    start_scan(2, 1'b1);
    goto(2, 8);
    abort[2] = 1'b1;
    @(posedge clk); #1;
    abort[2] = 1'b0;
    cont[2]  = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(out_valid[2]), 0);
    check("abort_busy",  32'(busy[2]),      0);
    check("abort_done",  32'(done[2]),      0);
    push_beat(2, 30, pat(30), 2);
    push_beat(2, 31, pat(31), 4);
    done_q[2].push_back(5);
    start_scan(2, 1'b0);
    goto(2, 8);

    // Write to reg 5 on the edge that captures it.
    rf[0][5] <= 32'hAAAA0000;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) push_beat(0, i, (i == 5) ? 32'hAAAA0000 : pat(i), 2 + 2 * i);
    done_q[0].push_back(65);
    start_scan(0, 1'b0);
    goto(0, 11);
    @(posedge clk);
    rf[0][5] <= 32'h5555FFFF;
    #1;
    goto(0, 67);
    for (int i = 0; i < 32; i++) push_beat(0, i, (i == 5) ? 32'h5555FFFF : pat(i), 2 + 2 * i);
    done_q[0].push_back(65);
    start_scan(0, 1'b0);
    goto(0, 67);
    rf[0][5] <= pat(5);

    // Asynchronous reset while presenting idx 1.
    push_beat(0, 0, pat(0), 2);
    start_scan(0, 1'b0);
    goto(0, 4);
    out_ready[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid[0]), 0);
    check("arst_busy",  32'(busy[0]),      0);
    check("arst_done",  32'(done[0]),      0);
    check("arst_addr",  32'(rd_addr[0]),   0);
    @(posedge clk); #1;
    rst_n        = 1'b1;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 32; i++) push_beat(0, i, pat(i), 2 + 2 * i);
    done_q[0].push_back(65);
    start_scan(0, 1'b0);
    goto(0, 67);

    for (int g = 0; g < 3; g++) begin
      check($sformatf("sb%0d_left", g),   32'(sb_q[g].size()),   0);
      check($sformatf("done%0d_left", g), 32'(done_q[g].size()), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
